// File: rtl/spi_access_sched.sv
`timescale 1ns/1ps
// spi_access_sched: arbitrates a shared SPI engine between a host trigger,
// a periodic poll timer and an external level request. The engine is given
// one transaction at a time and each transaction is guarded by a timeout.
//
// Handshake: a grant raises spi_start for one cycle and spi_src names the
// winner. The engine answers with a one-cycle spi_done. The external master
// holds ext_req until it sees the one-cycle ext_ack that closes its own
// transaction, whether that transaction completed or timed out.
module spi_access_sched #(
  parameter int PERIOD_CYC  = 100000,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        go,
  input  logic        ext_req,
  input  logic        spi_done,
  input  logic        err_clr,
  output logic        spi_start,
  output logic [1:0]  spi_src,
  output logic        busy,
  output logic        ext_ack,
  output logic        host_ovr,
  output logic        timeout_err,
  output logic [15:0] txn_count
);

  localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    rst_sync;
  logic          rst_ni;
  logic          go_d1, arm_d1;
  logic          go_rise, arm_rise, poll_evt;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] wait_cnt;
  logic          host_pend, timer_pend, ext_pend, ext_busy;
  logic [2:0]    req;
  logic [1:0]    last_q, c1, c2, gnt_src;
  logic          gnt_vld, grant, done_evt, tmo_evt;

  function automatic logic [1:0] rr_next(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // Reset asserts immediately and releases only on a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_ni = rst_sync[1];

  assign go_rise  = go & ~go_d1 & arm;
  assign arm_rise = arm & ~arm_d1;
  assign poll_evt = arm & ~arm_rise & (poll_cnt == POLL_LAST);
  // The ack cycle is masked so a master still dropping ext_req is not re-served
  assign ext_busy = (state_q == S_WAIT) && (spi_src == 2'd2);
  assign ext_pend = ext_req & ~ext_busy & ~ext_ack;
  assign req      = {ext_pend, timer_pend, host_pend};

  // Edge-detect history and the free-running poll counter
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      go_d1    <= 1'b0;
      arm_d1   <= 1'b0;
      poll_cnt <= '0;
    end else begin
      go_d1  <= go;
      arm_d1 <= arm;
      if (!arm || arm_rise || poll_cnt == POLL_LAST) poll_cnt <= '0;
      else                                           poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Round-robin pick starting just after the last granted source
  always_comb begin
    c1      = rr_next(last_q);
    c2      = rr_next(c1);
    gnt_vld = |req;
    if (req[c1])      gnt_src = c1;
    else if (req[c2]) gnt_src = c2;
    else              gnt_src = last_q;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: grant leaves IDLE, done or timeout leaves WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_vld) state_d = S_WAIT;
      S_WAIT:  if (spi_done || wait_cnt == TMO_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; a done in the timeout cycle counts as completion
  always_comb begin
    busy     = (state_q == S_WAIT);
    grant    = (state_q == S_IDLE) && gnt_vld;
    done_evt = (state_q == S_WAIT) && spi_done;
    tmo_evt  = (state_q == S_WAIT) && !spi_done && (wait_cnt == TMO_LAST);
  end

  // Grant bookkeeping, wait counter and completion reporting
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      spi_start   <= 1'b0;
      spi_src     <= 2'd0;
      last_q      <= 2'd2;
      wait_cnt    <= '0;
      ext_ack     <= 1'b0;
      txn_count   <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      spi_start <= grant;
      if (grant) begin
        spi_src <= gnt_src;
        last_q  <= gnt_src;
      end
      if (grant)        wait_cnt <= '0;
      else if (busy)    wait_cnt <= wait_cnt + 1'b1;
      ext_ack   <= (done_evt || tmo_evt) && (spi_src == 2'd2);
      txn_count <= txn_count + {15'd0, done_evt};
      if (tmo_evt)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  // Pending flags: a new event beats both the grant clear and the disarm clear
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      host_pend  <= 1'b0;
      timer_pend <= 1'b0;
      host_ovr   <= 1'b0;
    end else begin
      if (go_rise)                              host_pend <= 1'b1;
      else if (!arm)                            host_pend <= 1'b0;
      else if (grant && gnt_src == 2'd0)        host_pend <= 1'b0;
      if (poll_evt)                             timer_pend <= 1'b1;
      else if (!arm)                            timer_pend <= 1'b0;
      else if (grant && gnt_src == 2'd1)        timer_pend <= 1'b0;
      if (go_rise && host_pend)                 host_ovr <= 1'b1;
      else if (err_clr)                         host_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_access_sched.sv
`timescale 1ns/1ps
// Directed bench for spi_access_sched with a small poll period and timeout.
module tb_spi_access_sched;

  logic        clk = 1'b0;
  logic        rst_n, arm, go, ext_req, spi_done, err_clr;
  logic        spi_start, busy, ext_ack, host_ovr, timeout_err;
  logic [1:0]  spi_src;
  logic [15:0] txn_count;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] src_log[$];
  int         start_cyc_log[$];
  logic [1:0] exp_q[$];
  int         cyc = 0;
  int         done_dly = -1;
  int         done_cnt = 0;

  spi_access_sched #(.PERIOD_CYC(100), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .go(go), .ext_req(ext_req),
    .spi_done(spi_done), .err_clr(err_clr), .spi_start(spi_start),
    .spi_src(spi_src), .busy(busy), .ext_ack(ext_ack), .host_ovr(host_ovr),
    .timeout_err(timeout_err), .txn_count(txn_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, got running expected finished");
    $fatal(1);
  end

  // start logger and SPI engine model: done_dly cycles after each start
  initial begin
    spi_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      spi_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) spi_done = 1'b1;
      end
      if (spi_start === 1'b1) begin
        src_log.push_back(spi_src);
        start_cyc_log.push_back(cyc);
        if (done_dly > 0) done_cnt = done_dly;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; go = 1'b0; ext_req = 1'b0; err_clr = 1'b0;
    tick(2);
    src_log.delete();
    start_cyc_log.delete();
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic wait_start(input string tag, input int limit);
    int n = 0;
    while (spi_start !== 1'b1 && n < limit) begin tick(1); n++; end
    chk(tag, 32'(spi_start === 1'b1), 1);
  endtask

  task automatic wait_ack(input string tag, input int limit);
    int n = 0;
    while (ext_ack !== 1'b1 && n < limit) begin tick(1); n++; end
    chk(tag, 32'(ext_ack === 1'b1), 1);
  endtask

  task automatic count_busy(output int nb);
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy !== 1'b1) break;
      nb++;
      tick(1);
    end
  endtask

  function automatic int count_src(input logic [1:0] s);
    int c = 0;
    foreach (src_log[i]) if (src_log[i] == s) c++;
    return c;
  endfunction

  initial begin
    int nb;
    int n;

    // reset values
    rst_n = 1'b0; arm = 1'b0; go = 1'b0; ext_req = 1'b0; err_clr = 1'b0;
    tick(2);
    chk("rst_spi_start", 32'(spi_start), 0);
    chk("rst_spi_src", 32'(spi_src), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ext_ack", 32'(ext_ack), 0);
    chk("rst_host_ovr", 32'(host_ovr), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_txn_count", 32'(txn_count), 0);
    do_reset();

    // single host trigger: latency, busy length, count
    done_dly = 5;
    arm = 1'b1;
    tick(2);
    go = 1'b1;
    tick(1);
    go = 1'b0;
    chk("host_lat_early", 32'(spi_start), 0);
    tick(1);
    chk("host_lat_start", 32'(spi_start), 1);
    chk("host_src", 32'(spi_src), 0);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) nb++;
      tick(1);
    end
    chk("host_busy_cycles", 32'(nb), 6);
    chk("host_txn_count", 32'(txn_count), 1);
    chk("host_start_count", 32'(src_log.size()), 1);
    arm = 1'b0;
    tick(3);

    // periodic poll over 350 armed cycles
    done_dly = 2;
    src_log.delete();
    start_cyc_log.delete();
    arm = 1'b1;
    tick(350);
    arm = 1'b0;
    tick(5);
    chk("poll_start_count", 32'(src_log.size()), 3);
    foreach (src_log[i]) chk("poll_src", 32'(src_log[i]), 1);
    for (int i = 1; i < start_cyc_log.size(); i++)
      chk("poll_spacing", 32'(start_cyc_log[i] - start_cyc_log[i-1]), 100);
    chk("poll_txn_count", 32'(txn_count), 4);

    // all three sources pending together
    do_reset();
    done_dly = 2;
    arm = 1'b1;
    tick(100);
    go = 1'b1;
    tick(1);
    go = 1'b0;
    ext_req = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    n = 0;
    while (src_log.size() < 3 && n < 60) begin tick(1); n++; end
    chk("rr_three_grants", 32'(src_log.size() >= 3), 1);
    for (int i = 0; i < 3 && i < src_log.size(); i++)
      chk("rr_order", 32'(src_log[i]), 32'(exp_q.pop_front()));
    // ext_req held: a host trigger during an ext transaction is served next
    n = 0;
    while (!(busy === 1'b1 && spi_src == 2'd2) && n < 30) begin tick(1); n++; end
    chk("rr_ext_busy", 32'(busy === 1'b1 && spi_src == 2'd2), 1);
    go = 1'b1;
    tick(1);
    go = 1'b0;
    wait_start("rr_next_start", 30);
    chk("rr_host_before_ext", 32'(spi_src), 0);
    ext_req = 1'b0;
    arm = 1'b0;
    tick(5);

    // host overrun while waiting behind an ext transaction
    do_reset();
    done_dly = 8;
    arm = 1'b1;
    ext_req = 1'b1;
    wait_start("ovr_ext_start", 10);
    chk("ovr_ext_src", 32'(spi_src), 2);
    go = 1'b1; tick(1);
    go = 1'b0; tick(1);
    go = 1'b1; tick(1);
    go = 1'b0;
    chk("ovr_host_ovr", 32'(host_ovr), 1);
    wait_ack("ovr_ext_ack", 30);
    ext_req = 1'b0;
    tick(20);
    chk("ovr_host_grants", 32'(count_src(2'd0)), 1);
    chk("ovr_ext_grants", 32'(count_src(2'd2)), 1);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("ovr_err_clr", 32'(host_ovr), 0);
    arm = 1'b0;

    // ext transaction with no spi_done: timeout
    do_reset();
    done_dly = -1;
    ext_req = 1'b1;
    wait_start("tmo_start", 10);
    count_busy(nb);
    chk("tmo_wait_cycles", 32'(nb), 11);
    chk("tmo_ext_ack", 32'(ext_ack), 1);
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_txn_count", 32'(txn_count), 0);
    ext_req = 1'b0;
    tick(1);
    chk("tmo_ack_one_cycle", 32'(ext_ack), 0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("tmo_err_clr", 32'(timeout_err), 0);

    // spi_done in the timeout cycle counts as completion
    done_dly = 10;
    ext_req = 1'b1;
    wait_start("edge_start", 10);
    count_busy(nb);
    chk("edge_wait_cycles", 32'(nb), 11);
    chk("edge_txn_count", 32'(txn_count), 1);
    chk("edge_no_err", 32'(timeout_err), 0);
    chk("edge_ext_ack", 32'(ext_ack), 1);
    ext_req = 1'b0;

    // spi_done one cycle late lands in IDLE and is ignored
    done_dly = 11;
    ext_req = 1'b1;
    wait_start("late_start", 10);
    count_busy(nb);
    chk("late_wait_cycles", 32'(nb), 11);
    ext_req = 1'b0;
    tick(3);
    chk("late_txn_count", 32'(txn_count), 1);
    chk("late_err", 32'(timeout_err), 1);
    chk("late_idle", 32'(busy), 0);

    // disarm with timer pending while a transaction is in flight
    do_reset();
    done_dly = 8;
    arm = 1'b1;
    tick(95);
    ext_req = 1'b1;
    wait_start("disarm_start", 5);
    tick(6);
    arm = 1'b0;
    wait_ack("disarm_ack", 20);
    ext_req = 1'b0;
    tick(150);
    chk("disarm_no_poll", 32'(count_src(2'd1)), 0);
    chk("disarm_grants", 32'(src_log.size()), 1);
    chk("disarm_txn_count", 32'(txn_count), 1);

    // reset in the middle of an ext transaction
    done_dly = -1;
    ext_req = 1'b1;
    wait_start("mid_rst_start", 10);
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_src", 32'(spi_src), 0);
    ext_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (ext_ack === 1'b1) n++;
      tick(1);
    end
    chk("mid_rst_no_ack", 32'(n), 0);
    chk("mid_rst_txn_count", 32'(txn_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
